// File: rtl/serial_octal_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_octal_adder
//  Description : Digit-serial adder for octal digit streams (LSD first) with
//                internal carry, final carry digit and valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_octal_adder #(
    parameter int MAX_DIGITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_sum,
    output logic       out_last,
    output logic [3:0] digit_count,
    output logic       err_len
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] c_last_idx = 4'(MAX_DIGITS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_carry;
    logic       w_carry_nxt;
    logic       r_out_valid;
    logic       w_out_valid_nxt;
    logic [2:0] r_out_sum;
    logic [2:0] w_out_sum_nxt;
    logic       r_out_last;
    logic       w_out_last_nxt;
    logic [3:0] r_digit_count;
    logic [3:0] w_digit_count_nxt;
    logic       r_err_len;
    logic       w_err_len_nxt;

    logic       w_out_free;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_final;
    logic [3:0] w_t;

    // Output slot is reusable when empty or being drained this very cycle.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = (r_state == ST_RUN) && w_out_free && !rst;
    assign w_accept   = in_valid && w_in_ready;
    assign w_t        = {1'b0, in_a} + {1'b0, in_b} + {3'b000, r_carry};
    assign w_final    = in_last || (r_digit_count == c_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_carry       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_sum     <= 3'd0;
            r_out_last    <= 1'b0;
            r_digit_count <= 4'd0;
            r_err_len     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_carry       <= w_carry_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_sum     <= w_out_sum_nxt;
            r_out_last    <= w_out_last_nxt;
            r_digit_count <= w_digit_count_nxt;
            r_err_len     <= w_err_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_carry_nxt       = r_carry;
        w_out_valid_nxt   = r_out_valid;
        w_out_sum_nxt     = r_out_sum;
        w_out_last_nxt    = r_out_last;
        w_digit_count_nxt = r_digit_count;
        w_err_len_nxt     = r_err_len;

        if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    w_out_sum_nxt     = w_t[2:0];
                    w_out_valid_nxt   = 1'b1;
                    w_carry_nxt       = w_t[3];
                    w_digit_count_nxt = r_digit_count + 4'd1;
                    w_out_last_nxt    = 1'b0;
                    if (w_final) begin
                        w_digit_count_nxt = 4'd0;
                        if (!in_last) begin
                            w_err_len_nxt = 1'b1;
                        end
                        // A carry out of the top digit needs one more output digit.
                        if (w_t[3]) begin
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            w_out_last_nxt = 1'b1;
                            w_carry_nxt    = 1'b0;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (w_out_free) begin
                    w_out_sum_nxt   = 3'd1;
                    w_out_last_nxt  = 1'b1;
                    w_out_valid_nxt = 1'b1;
                    w_carry_nxt     = 1'b0;
                    w_state_nxt     = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_sum     = r_out_sum;
    assign out_last    = r_out_last;
    assign digit_count = r_digit_count;
    assign err_len     = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_serial_octal_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_octal_adder
//  Description : Directed scoreboard bench for serial_octal_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_octal_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sum;
    logic       out_last;
    logic [3:0] digit_count;
    logic       err_len;

    int checks;
    int failures;
    logic [3:0] exp_q[$];   // {last, sum}

    serial_octal_adder #(.MAX_DIGITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_last    (out_last),
        .digit_count (digit_count),
        .err_len     (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] sum, input logic last);
        exp_q.push_back({last, sum});
    endtask

    // Present a digit pair and return 1ns after the edge that accepts it.
    task automatic send(input logic [2:0] a, input logic [2:0] b, input logic last);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            chk("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: each presented output digit is seen at exactly one negedge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [3:0] e;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {28'd0, out_last, out_sum}, 99);
            end else begin
                e = exp_q.pop_front();
                chk("out_sum", int'(out_sum), int'(e[2:0]));
                chk("out_last", int'(out_last), int'(e[3]));
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 3'd0;
        in_b      = 3'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_digit_count", int'(digit_count), 0);
        chk("rst_err_len", int'(err_len), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // 2 + 2
        push(3'd4, 1'b1);
        send(3'd2, 3'd2, 1'b1);
        chk("lat_out_valid", int'(out_valid), 1);
        chk("lat_out_sum", int'(out_sum), 4);
        chk("single_err_len", int'(err_len), 0);

        // 3 + 7 = 0o12
        push(3'd2, 1'b0);
        push(3'd1, 1'b1);
        send(3'd3, 3'd7, 1'b1);
        chk("flush_in_ready", int'(in_ready), 0);
        idle(1);
        chk("after_flush_in_ready", int'(in_ready), 1);

        // 0o77 + 0o01 = 0o100
        push(3'd0, 1'b0);
        push(3'd0, 1'b0);
        push(3'd1, 1'b1);
        send(3'd7, 3'd1, 1'b0);
        chk("dc_after_first", int'(digit_count), 1);
        send(3'd7, 3'd0, 1'b1);
        chk("dc_after_last", int'(digit_count), 0);
        idle(3);

        // Backpressure: 5 + 1 held, 2 + 2 waits
        out_ready = 1'b0;
        push(3'd6, 1'b1);
        send(3'd5, 3'd1, 1'b1);
        push(3'd4, 1'b1);
        in_valid = 1'b1;
        in_a     = 3'd2;
        in_b     = 3'd2;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_sum", int'(out_sum), 6);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_sum", int'(out_sum), 4);
        chk("bp_second_valid", int'(out_valid), 1);
        idle(2);

        // Length overflow: eight 7+1 digits, no in_last
        push(3'd0, 1'b0);
        for (int i = 0; i < 7; i++) push(3'd1, 1'b0);
        push(3'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("err_len_before", int'(err_len), 0);
            send(3'd7, 3'd1, 1'b0);
        end
        chk("ovf_err_len", int'(err_len), 1);
        chk("ovf_dc", int'(digit_count), 0);
        idle(4);
        chk("ovf_err_len_sticky", int'(err_len), 1);

        // Reset mid-number
        push(3'd6, 1'b0);
        send(3'd7, 3'd7, 1'b0);
        chk("mid_dc", int'(digit_count), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_dc", int'(digit_count), 0);
        chk("mid_rst_err_len", int'(err_len), 0);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        push(3'd2, 1'b1);
        send(3'd1, 3'd1, 1'b1);
        chk("mid_sum", int'(out_sum), 2);
        chk("mid_last", int'(out_last), 1);
        @(posedge clk);
        #1;
        chk("mid_no_flush", int'(out_valid), 0);

        // Drain scoreboard
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_octal_adder.md
# serial_octal_adder

Digit-serial adder built around the 3-bit add stage. It accepts two operands as a stream of 3-bit (octal) digit pairs, least significant digit first, and carries between digits internally. It emits the sum as a registered 3-bit digit stream, appending a final carry digit when needed. This lets the 3-bit datapath add numbers of arbitrary length up to MAX_DIGITS, with valid/ready flow control on both sides.

## Interface
- MAX_DIGITS, 8, maximum input digits per operand; legal range 2..15
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input digit pair valid
- in_ready  out  1  block can accept input digit pair
- in_a  in  3  operand A digit
- in_b  in  3  operand B digit
- in_last  in  1  marks most significant digit of current operands
- out_valid  out  1  output digit valid
- out_ready  in  1  downstream accepts output digit
- out_sum  out  3  sum digit
- out_last  out  1  marks final digit of current sum
- digit_count  out  4  input digits accepted so far in current operand
- err_len  out  1  sticky; length overflow occurred

## Operation
- States: RUN (accepting digits) and FLUSH (carry digit pending). Reset state is RUN.
- Internal carry_reg holds 1 bit. It is cleared at reset and at the end of every number.
- Output register is free when out_valid is 0, or when out_ready is 1 this cycle.
- in_ready is 1 only when state is RUN, the output register is free, and rst is 0.
- On accept (in_valid & in_ready):
  - compute 4-bit t = in_a + in_b + carry_reg
  - out_sum <= t[2:0], out_valid <= 1, carry_reg <= t[3]
  - digit_count <= digit_count + 1
- A digit is final when in_last = 1, or when digit_count = MAX_DIGITS-1 at accept time (forced final).
- Final digit with t[3] = 0:
  - out_last <= 1
  - carry_reg <= 0, digit_count <= 0; stay in RUN
- Final digit with t[3] = 1:
  - out_last <= 0
  - digit_count <= 0; go to FLUSH
- In FLUSH, when the output register is free:
  - out_sum <= 3'd1, out_last <= 1, out_valid <= 1
  - carry_reg <= 0; go to RUN
- Non-final accept: out_last <= 0.
- Forced final with in_last = 0 sets err_len <= 1. err_len is held until rst. The number is terminated normally, including the carry flush.
- Output handshake: when out_valid & out_ready and nothing new is loaded, out_valid <= 0.
- The block supports simultaneous output drain and new accept in the same cycle, giving full throughput.

## Timing
- Reset values: out_valid 0, out_sum 0, out_last 0, digit_count 0, err_len 0, carry_reg 0, state RUN.
- in_ready is 0 in the reset cycle and 1 in the first cycle after rst deasserts.
- Latency: the digit accepted at edge N is on out_sum with out_valid=1 after edge N.
- Throughput: 1 digit/cycle when out_ready is held 1.
- A carry-out number costs one extra cycle (FLUSH), during which in_ready = 0.
- While out_valid & !out_ready:
  - out_sum and out_last are held stable
  - in_ready = 0
  - FLUSH waits
- rst mid-number: the number is abandoned with no flush digit. The next digit accepted starts with carry 0 and digit_count 0.
- in_last on the digit where digit_count = MAX_DIGITS-1 is a legal maximum-length operand. It does not set err_len.
- in_a, in_b and in_last are ignored when not accepted.

## Test plan
- 2+2 single digit, in_last=1, out_ready=1:
  - one output, out_sum=4, out_last=1, one cycle after accept
  - err_len stays 0
- 3+7 single digit, in_last=1:
  - out_sum=2, out_last=0, then out_sum=1, out_last=1 (0o12 = 10)
  - in_ready=0 during the FLUSH cycle
- A=0o77 (digits 7,7), B=0o01 (digits 1,0), back-to-back:
  - outputs 0,0,1; only the third has out_last=1 (64 = 0o100)
  - digit_count goes 1 then 0
- Backpressure: start 5+1 (single digit) with out_ready=0 for 3 cycles:
  - out_sum=6 held with out_valid=1
  - in_ready=0 throughout
  - a 2nd digit pair 2+2 is presented in the same window and is accepted only after out_ready rises; its output 4 follows one cycle later
- Length overflow, MAX_DIGITS=8:
  - 8 digit pairs 7+1, all in_last=0
  - the 8th output is 1 with out_last=0, then a flush digit 1 with out_last=1
  - err_len=1 and stays 1 until rst
- Reset mid-number:
  - accept 7+7 (carry pending, non-final), assert rst for 1 cycle
  - then 1+1 with in_last=1 gives out_sum=2, out_last=1, with no stale carry or flush digit
